// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, taken branch and
// I/D-cache miss handling, plus a saturating count of PC-stalled cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       id_regA,
  input  logic [REG_W-1:0]       id_regB,
  input  logic                   id_uses_regB,
  input  logic                   ex_mem_r_en,
  input  logic [REG_W-1:0]       ex_regD,
  input  logic                   ex_branch_taken,
  input  logic                   ic_miss,
  input  logic                   ic_ready,
  input  logic                   dc_miss,
  input  logic                   dc_ready,
  input  logic                   stat_clr,
  output logic                   pc_en,
  output logic                   pc_redirect,
  output logic                   en_fetch,
  output logic                   en_decode,
  output logic                   en_alu,
  output logic                   en_mem,
  output logic                   flush_fetch,
  output logic                   flush_decode,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {StRun = 2'd0, StIwait = 2'd1, StDwait = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic                   ic_pend_q, ic_pend_d;
  logic                   br_pend_q, br_pend_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   load_use;
  logic                   run_eval, run_dmiss, run_imiss;

  assign load_use = ex_mem_r_en && (ex_regD != '0) &&
                    ((ex_regD == id_regA) || (id_uses_regB && (ex_regD == id_regB)));

  always_comb begin
    state_d      = state_q;
    ic_pend_d    = ic_pend_q;
    br_pend_d    = br_pend_q;
    pc_en        = 1'b1;
    pc_redirect  = 1'b0;
    en_fetch     = 1'b1;
    en_decode    = 1'b1;
    en_alu       = 1'b1;
    en_mem       = 1'b1;
    flush_fetch  = 1'b0;
    flush_decode = 1'b0;
    run_eval     = 1'b0;
    run_dmiss    = 1'b0;
    run_imiss    = 1'b0;

    unique case (state_q)
      StRun: begin
        run_eval  = 1'b1;
        run_dmiss = dc_miss;
        run_imiss = ic_miss;
      end
      StIwait: begin
        if (dc_miss) begin
          {pc_en, en_fetch, en_decode, en_alu, en_mem} = '0;
          state_d   = StDwait;
          ic_pend_d = !ic_ready;
        end else if (!ic_ready) begin
          pc_en       = 1'b0;
          en_fetch    = 1'b0;
          flush_fetch = 1'b1;
          if (ex_branch_taken) begin
            // Target is latched now; redirect waits for the refill to land.
            flush_decode = 1'b1;
            br_pend_d    = 1'b1;
          end
        end else begin
          state_d   = StRun;
          br_pend_d = 1'b0;
          if (br_pend_q && !ex_branch_taken) begin
            flush_fetch = 1'b1;
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
          end else begin
            run_eval = 1'b1;
          end
        end
      end
      StDwait: begin
        if (!dc_ready) begin
          {pc_en, en_fetch, en_decode, en_alu, en_mem} = '0;
          if (ic_ready) ic_pend_d = 1'b0;
        end else begin
          ic_pend_d = 1'b0;
          state_d   = (ic_pend_q && !ic_ready) ? StIwait : StRun;
          // A branch latched in IWAIT whose refill finished during the freeze.
          if (br_pend_q && !(ic_pend_q && !ic_ready) && !ex_branch_taken) begin
            br_pend_d   = 1'b0;
            flush_fetch = 1'b1;
            pc_redirect = 1'b1;
          end else begin
            run_eval  = 1'b1;
            run_imiss = ic_miss;
          end
        end
      end
      default: state_d = StRun;
    endcase

    if (run_eval) begin
      if (run_dmiss) begin
        {pc_en, en_fetch, en_decode, en_alu, en_mem} = '0;
        state_d = StDwait;
      end else if (ex_branch_taken) begin
        flush_fetch  = 1'b1;
        flush_decode = 1'b1;
        pc_redirect  = 1'b1;
        br_pend_d    = 1'b0;
      end else if (run_imiss) begin
        pc_en       = 1'b0;
        en_fetch    = 1'b0;
        flush_fetch = 1'b1;
        state_d     = StIwait;
      end else if (load_use) begin
        pc_en        = 1'b0;
        en_fetch     = 1'b0;
        flush_decode = 1'b1;
      end
    end

    if (!reset) begin
      {pc_en, pc_redirect, en_fetch, en_decode, en_alu, en_mem} = '0;
      {flush_fetch, flush_decode} = '0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stat_clr) begin
      stall_count_d = '0;
    end else if (!pc_en && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      ic_pend_q     <= 1'b0;
      br_pend_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ic_pend_q     <= ic_pend_d;
      br_pend_q     <= br_pend_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule
